vram_scanout: RTL and testbench

- Display-side reader of the dual-port VRAM. The CPU writes the VRAM through port A; this block owns port B.
- Generates 640x480@60 VGA timing from the pixel clock and scans a 160x120, 1-bit-per-pixel framebuffer.
- Each framebuffer pixel is replicated 4x4 on screen.
- Drives the 15-bit VRAM read address, selects the correct 4K x 1 bank output, and produces registered 8-bit RGB (2/3/3) plus sync and blanking status.

---
 rtl/vram_scanout.sv | 175 +++++++++++++++++
 tb/tb_vram_scanout.sv | 129 ++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// VGA 640x480@60 scan-out of a 160x120 1bpp framebuffer held in five 4K x 1 VRAM banks.
// Three-stage pipeline: address, bank select, registered colour; sync and blank travel
// through the same stages so every output lags the counters by exactly three cycles.
module vram_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          FB_WIDTH = 160,
    parameter logic [7:0]  FG_COLOR = 8'hFF,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_en,
    output logic [14:0] vram_addr,
    input  logic [4:0]  vram_data,
    output logic [1:0]  red,
    output logic [2:0]  green,
    output logic [2:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank,
    output logic        frame_start
);

    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] STRIDE   = 15'(FB_WIDTH);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [14:0] row_base_q, row_base_d;
    logic [14:0] vram_addr_q, vram_addr_d;

    logic        h_act, v_act, line_end, frame_end;
    logic        hs_on, vs_on;

    // stage 1 / stage 2 copies of the timing flags; hs/vs are stored active-low
    logic        act1_q, hs1_q, vs1_q, vb1_q, fs1_q;
    logic        act2_q, hs2_q, vs2_q, vb2_q, fs2_q;
    logic [2:0]  bsel_q;
    logic        pix;

    logic [7:0]  rgb_q, rgb_d;
    logic        hsync_q, vsync_q, vblank_q, frame_start_q;

    assign h_act     = (h_cnt_q < H_ACT);
    assign v_act     = (v_cnt_q < V_ACT);
    assign line_end  = (h_cnt_q == H_LAST);
    assign frame_end = line_end && (v_cnt_q == V_LAST);
    assign hs_on     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_on     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    // Counter, row base and address next-state; the row base steps once every four lines
    always_comb begin
        h_cnt_d     = line_end ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d     = v_cnt_q;
        row_base_d  = row_base_q;
        vram_addr_d = vram_addr_q;
        if (line_end) begin
            v_cnt_d = frame_end ? 10'd0 : v_cnt_q + 10'd1;
        end
        if (frame_end) begin
            row_base_d = 15'd0;
        end else if (line_end && (v_cnt_q[1:0] == 2'd3) && v_act) begin
            row_base_d = row_base_q + STRIDE;
        end
        if (h_act && v_act) begin
            vram_addr_d = row_base_q + {7'd0, h_cnt_q[9:2]};
        end
    end

    // Counters and stage-1 registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q     <= 10'd0;
            v_cnt_q     <= 10'd0;
            row_base_q  <= 15'd0;
            vram_addr_q <= 15'd0;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vb1_q       <= 1'b0;
            fs1_q       <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            row_base_q  <= row_base_d;
            vram_addr_q <= vram_addr_d;
            act1_q      <= h_act && v_act;
            hs1_q       <= !hs_on;
            vs1_q       <= !vs_on;
            vb1_q       <= !v_act;
            fs1_q       <= (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end
    end

    // Stage 2: bank index delayed to line up with the RAM's registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bsel_q <= 3'd0;
            act2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            vb2_q  <= 1'b0;
            fs2_q  <= 1'b0;
        end else begin
            bsel_q <= vram_addr_q[14:12];
            act2_q <= act1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            vb2_q  <= vb1_q;
            fs2_q  <= fs1_q;
        end
    end

    // Bank mux; unused bank codes read as background
    always_comb begin
        pix = 1'b0;
        case (bsel_q)
            3'd0:    pix = vram_data[0];
            3'd1:    pix = vram_data[1];
            3'd2:    pix = vram_data[2];
            3'd3:    pix = vram_data[3];
            3'd4:    pix = vram_data[4];
            default: pix = 1'b0;
        endcase
    end

    // Colour select with blanking and video enable applied at the output stage
    always_comb begin
        rgb_d = 8'h00;
        if (act2_q && video_en) begin
            rgb_d = pix ? FG_COLOR : BG_COLOR;
        end
    end

    // Stage 3 output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q         <= 8'h00;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= hs2_q;
            vsync_q       <= vs2_q;
            vblank_q      <= vb2_q;
            frame_start_q <= fs2_q;
        end
    end

    assign vram_addr   = vram_addr_q;
    assign red         = rgb_q[7:6];
    assign green       = rgb_q[5:3];
    assign blue        = rgb_q[2:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout: directed run through lines 0..104 with a one-bit RAM image,
// a video_en dropout on line 102 and a mid-line reset, checked against a cycle model.
module tb_vram_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        video_en = 1'b1;
    logic [14:0] vram_addr;
    logic [4:0]  vram_data = 5'd0;
    logic [1:0]  red;
    logic [2:0]  green;
    logic [2:0]  blue;
    logic        hsync, vsync, vblank, frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int n        = 0;
    int exp_addr = 0;
    int fg_seen  = 0;
    logic en_prev = 1'b1;

    vram_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .video_en    (video_en),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Synchronous RAM: only bank 1, bit 0 (address 4096) holds a 1
    always @(posedge clk) vram_data <= {3'b000, (vram_addr[11:0] == 12'd0), 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", tag, got, exp, n, $time);
    endtask

    // Expected {rgb, hsync, vsync, vblank, frame_start} at cycle k after release
    function automatic logic [11:0] exp_out(input int k, input logic en_p);
        int m, hd, vd;
        logic act, pix;
        logic [7:0] rgb;
        if (k < 3) return 12'h00C;
        m   = k - 3;
        hd  = m % 800;
        vd  = (m / 800) % 525;
        act = (hd < 640) && (vd < 480);
        pix = ((160 * (vd / 4) + hd / 4) == 4096);
        rgb = (act && en_p && pix) ? 8'hFF : 8'h00;
        return {rgb, !(hd >= 656 && hd < 752), !(vd >= 490 && vd < 492), (vd >= 480), (hd == 0 && vd == 0)};
    endfunction

    function automatic logic [11:0] outs();
        return {red, green, blue, hsync, vsync, vblank, frame_start};
    endfunction

    task automatic step(input bit do_chk);
        int h, v;
        en_prev = video_en;
        h = n % 800;
        v = (n / 800) % 525;
        if (h < 640 && v < 480) exp_addr = 160 * (v / 4) + h / 4;
        @(posedge clk);
        #1;
        n++;
        if ({red, green, blue} == 8'hFF) fg_seen++;
        if (do_chk) begin
            chk("out", 32'(outs()), 32'(exp_out(n, en_prev)));
            chk("addr", 32'(vram_addr), exp_addr);
        end
    endtask

    initial begin
        reset    = 1'b0;
        video_en = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("rst_out", 32'(outs()), 32'h00C);
            chk("rst_addr", 32'(vram_addr), 0);
        end
        reset    = 1'b1;
        n        = 0;
        exp_addr = 0;
        chk("rel_out", 32'(outs()), 32'(exp_out(0, 1'b1)));

        // Lines 0..104; blank video_en for h=388..399 on line 102 to cut the FG run in half
        while (n < 104 * 800 + 300) begin
            video_en = !((n / 800) == 102 && (n % 800) >= 388 && (n % 800) < 400);
            step(((n + 1) / 800) <= 5 || ((n + 1) / 800) >= 99);
        end
        chk("fg_count", fg_seen, 14);

        // Mid-line reset: outputs must drop to reset values without a clock edge
        video_en = 1'b1;
        reset    = 1'b0;
        #1;
        chk("midrst_out", 32'(outs()), 32'h00C);
        chk("midrst_addr", 32'(vram_addr), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_hold", 32'(outs()), 32'h00C);
        end
        reset    = 1'b1;
        n        = 0;
        exp_addr = 0;
        fg_seen  = 0;
        chk("rerel_out", 32'(outs()), 32'(exp_out(0, 1'b1)));
        while (n < 4 * 800 + 200) begin
            step(1'b1);
        end
        chk("rerun_fg", fg_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
